commit_monitor: RTL

Receiving end of the CPU core's commit interface. Captures every retired instruction (`commit`, `commit_instr`, `commit_pc`, `commit_pre_pc`) into a small FIFO, tags each entry with a retire sequence number, and drains entries to a debug or trace consumer over a valid/ready handshake. An optional checker flags PC-continuity breaks between consecutive commits. Sits beside the core top in simulation and FPGA debug builds, driven directly from the core's commit outputs.

---
 rtl/commit_monitor.sv | 131 +++++++++++++
 1 files changed

// File: rtl/commit_monitor.sv
// commit_monitor: captures retired instructions from the core's commit port
// into a DEPTH-entry FIFO, tags each with a retire sequence number and drains
// them over a valid/ready handshake to a debug or trace consumer.
//
// Build option: define COMMIT_MON_CHECK_EN to include the PC-continuity
// checker. Without it, mismatch and mismatch_pc are tied to zero and the
// port list is unchanged.
module commit_monitor #(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit,
  input  logic [31:0]      commit_instr,
  input  logic [63:0]      commit_pre_pc,
  input  logic [63:0]      commit_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [63:0]      out_pre_pc,
  output logic [63:0]      out_pc,
  output logic [SEQ_W-1:0] out_seq,
  output logic             overflow,
  output logic [SEQ_W-1:0] commit_count,
  output logic             mismatch,
  output logic [63:0]      mismatch_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0]      instr;
    logic [63:0]      pre_pc;
    logic [63:0]      pc;
    logic [SEQ_W-1:0] seq;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [SEQ_W-1:0] r_commit_count;
  logic             r_overflow;

  logic   w_full;
  logic   w_pop;
  logic   w_push;
  entry_t w_head;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = out_valid && out_ready;
  assign w_push  = commit && (!w_full || w_pop);
  assign w_head  = r_mem[r_rd_ptr];

  assign out_valid    = (r_count != '0);
  assign out_instr    = w_head.instr;
  assign out_pre_pc   = w_head.pre_pc;
  assign out_pc       = w_head.pc;
  assign out_seq      = w_head.seq;
  assign overflow     = r_overflow;
  assign commit_count = r_commit_count;

  // Entry storage: written at the write pointer on every accepted push.
  // NOTE: storage is deliberately not reset; out_valid guards stale contents,
  // and leaving it out of reset keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= '{instr:  commit_instr,
                           pre_pc: commit_pre_pc,
                           pc:     commit_pc,
                           seq:    r_commit_count};
    end
  end

  // Pointers, occupancy, retire counter and sticky overflow flag.
  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_commit_count <= '0;
      r_overflow     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
      // Dropped commits are still counted so the consumer sees a seq gap.
      if (commit) r_commit_count <= r_commit_count + SEQ_W'(1);
      if (commit && !w_push) r_overflow <= 1'b1;
    end
  end

`ifdef COMMIT_MON_CHECK_EN
  logic [63:0] r_last_pc;
  logic        r_have_last;
  logic        r_mismatch;
  logic [63:0] r_mismatch_pc;

  // Continuity checker: each commit's PC must equal the previous next-PC;
  // it watches every commit, including those the FIFO drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_pc     <= '0;
      r_have_last   <= 1'b0;
      r_mismatch    <= 1'b0;
      r_mismatch_pc <= '0;
    end else if (commit) begin
      if (r_have_last && (commit_pre_pc != r_last_pc) && !r_mismatch) begin
        r_mismatch    <= 1'b1;
        r_mismatch_pc <= commit_pre_pc;
      end
      r_last_pc   <= commit_pc;
      r_have_last <= 1'b1;
    end
  end

  assign mismatch    = r_mismatch;
  assign mismatch_pc = r_mismatch_pc;
`else
  assign mismatch    = 1'b0;
  assign mismatch_pc = '0;
`endif

endmodule
